// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
// Brings an asynchronous up/down ripple counter into the CLK domain. The
// COUNT/UPDN lines are double-flop synchronised, ripple glitches are rejected
// by a run-length stability filter, and each accepted value is classified
// (wrap, compare match, step skip) and queued in a small event FIFO.
//
// Optional feature macro: RCM_SKIP_DETECT_EN
//   defined   : SKIP flag compares the new value against old +/- 1
//   undefined : SKIP flag tied to 0, comparison logic removed
//
// Ports
//   CLK         system clock, rising edge
//   RESET_N     asynchronous active-low reset
//   COUNT_IN    ripple counter value (asynchronous)
//   UPDN_IN     counter direction, 1 = up (asynchronous)
//   CMP_VAL     quasi-static compare value
//   COUNT_SYNC  last accepted count
//   CHANGE      one-cycle pulse per acceptance
//   EVT_VALID   event FIFO non-empty
//   EVT_READY   consumer takes head entry
//   EVT_COUNT   head entry count
//   EVT_FLAGS   head entry flags {SKIP, MATCH, WRAP}
//   OVF         sticky: an event was dropped on a full FIFO
module ripple_count_monitor #(
   parameter int unsigned WIDTH         = 4,
   parameter int unsigned STABLE_CYCLES = 2,
   parameter int unsigned DEPTH         = 4
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [WIDTH-1:0] COUNT_IN,
   input  logic             UPDN_IN,
   input  logic [WIDTH-1:0] CMP_VAL,
   output logic [WIDTH-1:0] COUNT_SYNC,
   output logic             CHANGE,
   output logic             EVT_VALID,
   input  logic             EVT_READY,
   output logic [WIDTH-1:0] EVT_COUNT,
   output logic [2:0]       EVT_FLAGS,
   output logic             OVF
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned EW = WIDTH + 3;
   localparam int unsigned RW = 3;
   localparam logic [WIDTH-1:0] MAX_VAL   = '1;
   localparam logic [RW-1:0]    RUN_MAX   = '1;
   localparam logic [RW-1:0]    RUN_NEED  = RW'(STABLE_CYCLES);
   localparam logic [AW:0]      DEPTH_OCC = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] cnt_s1, cnt_s2;
   logic             dir_s1, dir_s2;
   logic [RW-1:0]    run;
   logic             accept;
   logic             wrap, match, skip;

   logic [EW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      occ;
   logic             full, pop, write_en;
   logic [EW-1:0]    head;

   // Two-flop synchronisers plus run-length counter of the s2 value.
   // cnt_s1 is the next s2, so a mismatch here means s2 changes this edge.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_s1 <= '0;
         cnt_s2 <= '0;
         dir_s1 <= 1'b0;
         dir_s2 <= 1'b0;
         run    <= '0;
      end else begin
         cnt_s1 <= COUNT_IN;
         cnt_s2 <= cnt_s1;
         dir_s1 <= UPDN_IN;
         dir_s2 <= dir_s1;
         if (cnt_s1 != cnt_s2) begin
            run <= RW'(1);
         end else if (run != RUN_MAX) begin
            run <= run + RW'(1);
         end
      end
   end

   // Acceptance and classification of the stable s2 value.
   always_comb begin
      accept = (run >= RUN_NEED) && (cnt_s2 != COUNT_SYNC);
      wrap   = dir_s2 ? ((COUNT_SYNC == MAX_VAL) && (cnt_s2 == '0))
                      : ((COUNT_SYNC == '0) && (cnt_s2 == MAX_VAL));
      match  = (cnt_s2 == CMP_VAL);
`ifdef RCM_SKIP_DETECT_EN
      skip   = dir_s2 ? (cnt_s2 != COUNT_SYNC + WIDTH'(1))
                      : (cnt_s2 != COUNT_SYNC - WIDTH'(1));
`else
      skip   = 1'b0;
`endif
   end

   // Accepted value register and change pulse.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         COUNT_SYNC <= '0;
         CHANGE     <= 1'b0;
      end else begin
         CHANGE <= accept;
         if (accept) begin
            COUNT_SYNC <= cnt_s2;
         end
      end
   end

   // FIFO control; a push on a full FIFO only lands if a pop frees the slot.
   always_comb begin
      full     = (occ == DEPTH_OCC);
      pop      = EVT_VALID && EVT_READY;
      write_en = accept && (!full || pop);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         OVF    <= 1'b0;
      end else begin
         if (write_en) begin
            mem[wr_ptr] <= {cnt_s2, skip, match, wrap};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({write_en, pop})
            2'b10:   occ <= occ + (AW + 1)'(1);
            2'b01:   occ <= occ - (AW + 1)'(1);
            default: occ <= occ;
         endcase
         if (accept && full && !pop) begin
            OVF <= 1'b1;
         end
      end
   end

   // Head entry presented directly from storage; stable until popped.
   always_comb begin
      head      = mem[rd_ptr];
      EVT_VALID = (occ != '0);
      EVT_COUNT = head[EW-1:3];
      EVT_FLAGS = head[2:0];
   end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor (WIDTH=4, STABLE_CYCLES=2, DEPTH=4).
// Expected events are queued when stimulus is driven and compared when the
// DUT presents them with EVT_VALID & EVT_READY.
module tb_ripple_count_monitor;

   localparam int unsigned WIDTH         = 4;
   localparam int unsigned STABLE_CYCLES = 2;
   localparam int unsigned DEPTH         = 4;
`ifdef RCM_SKIP_DETECT_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RESET_N;
   logic [WIDTH-1:0] COUNT_IN;
   logic             UPDN_IN;
   logic [WIDTH-1:0] CMP_VAL;
   logic [WIDTH-1:0] COUNT_SYNC;
   logic             CHANGE;
   logic             EVT_VALID;
   logic             EVT_READY;
   logic [WIDTH-1:0] EVT_COUNT;
   logic [2:0]       EVT_FLAGS;
   logic             OVF;

   ripple_count_monitor #(
      .WIDTH(WIDTH), .STABLE_CYCLES(STABLE_CYCLES), .DEPTH(DEPTH)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .COUNT_IN(COUNT_IN), .UPDN_IN(UPDN_IN),
      .CMP_VAL(CMP_VAL), .COUNT_SYNC(COUNT_SYNC), .CHANGE(CHANGE),
      .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_COUNT(EVT_COUNT),
      .EVT_FLAGS(EVT_FLAGS), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] count;
      logic       updn;
      logic [3:0] cmp;
      int         hold;
      bit         ev;
      logic [2:0] flags;
      logic [3:0] sync;
   } vec_t;

   vec_t       vecs[11];
   logic [6:0] sb[$];
   int         checks = 0;
   int         errors = 0;
   int         pops   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] mk(input logic [3:0] c, input logic [2:0] f);
      return {c, f & {SKIP_EN, 2'b11}};
   endfunction

   // Drive a new counter value just after a rising edge.
   task automatic drive(input logic [3:0] c, input logic u, input logic [3:0] m);
      @(posedge CLK);
      #1;
      COUNT_IN = c;
      UPDN_IN  = u;
      CMP_VAL  = m;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && EVT_VALID; i++) begin
         @(posedge CLK);
         #1;
      end
      check({name, "_drained"}, 32'(EVT_VALID), 32'd0);
   endtask

   // Scoreboard: compare every handshaked head entry with the oldest expectation.
   always @(negedge CLK) begin
      if (RESET_N && EVT_VALID && EVT_READY) begin
         pops++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %0h expected none", {EVT_COUNT, EVT_FLAGS});
         end else begin
            check("event", 32'({EVT_COUNT, EVT_FLAGS}), 32'(sb.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{4'd14, 1'b1, 4'd9,  8, 1'b1, 3'b100, 4'd14};
      vecs[1]  = '{4'd15, 1'b1, 4'd9,  8, 1'b1, 3'b000, 4'd15};
      vecs[2]  = '{4'd0,  1'b1, 4'd9,  8, 1'b1, 3'b001, 4'd0};
      vecs[3]  = '{4'd7,  1'b1, 4'd9,  8, 1'b1, 3'b100, 4'd7};
      vecs[4]  = '{4'd6,  1'b1, 4'd9,  1, 1'b0, 3'b000, 4'd7};
      vecs[5]  = '{4'd8,  1'b1, 4'd9,  8, 1'b1, 3'b000, 4'd8};
      vecs[6]  = '{4'd4,  1'b0, 4'd3,  8, 1'b1, 3'b100, 4'd4};
      vecs[7]  = '{4'd3,  1'b0, 4'd3,  8, 1'b1, 3'b010, 4'd3};
      vecs[8]  = '{4'd0,  1'b0, 4'd3,  8, 1'b1, 3'b100, 4'd0};
      vecs[9]  = '{4'd15, 1'b0, 4'd15, 8, 1'b1, 3'b011, 4'd15};
      vecs[10] = '{4'd15, 1'b1, 4'd15, 8, 1'b0, 3'b000, 4'd15};

      // Reset with the counter already at 5
      RESET_N   = 1'b0;
      COUNT_IN  = 4'd5;
      UPDN_IN   = 1'b1;
      CMP_VAL   = 4'd9;
      EVT_READY = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_count_sync", 32'(COUNT_SYNC), 32'd0);
      check("rst_valid", 32'(EVT_VALID), 32'd0);
      check("rst_ovf", 32'(OVF), 32'd0);
      check("rst_evt_count", 32'(EVT_COUNT), 32'd0);
      check("rst_evt_flags", 32'(EVT_FLAGS), 32'd0);
      check("rst_change", 32'(CHANGE), 32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("lat_early_sync", 32'(COUNT_SYNC), 32'd0);
      check("lat_early_valid", 32'(EVT_VALID), 32'd0);
      sb.push_back(mk(4'd5, 3'b100));
      @(posedge CLK);
      #1;
      check("lat_sync", 32'(COUNT_SYNC), 32'd5);
      check("lat_change", 32'(CHANGE), 32'd1);
      check("lat_valid", 32'(EVT_VALID), 32'd1);
      check("lat_head", 32'({EVT_COUNT, EVT_FLAGS}), 32'(mk(4'd5, 3'b100)));
      @(posedge CLK);
      #1;
      check("change_pulse", 32'(CHANGE), 32'd0);
      EVT_READY = 1'b1;

      // Table: wrap, glitch, compare, down steps, direction-only change
      foreach (vecs[k]) begin
         drive(vecs[k].count, vecs[k].updn, vecs[k].cmp);
         if (vecs[k].ev) sb.push_back(mk(vecs[k].count, vecs[k].flags));
         repeat (vecs[k].hold - 1) @(posedge CLK);
         #1;
         check($sformatf("vec%0d_sync", k), 32'(COUNT_SYNC), 32'(vecs[k].sync));
      end
      check("table_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure: DEPTH+1 acceptances with READY low
      EVT_READY = 1'b0;
      for (int v = 1; v <= 5; v++) begin
         drive(4'(v), 1'b1, 4'd15);
         if (v == 1) sb.push_back(mk(4'd1, 3'b100));
         else if (v <= 4) sb.push_back(mk(4'(v), 3'b000));
         repeat (3) @(posedge CLK);
      end
      repeat (4) @(posedge CLK);
      #1;
      check("bp_ovf", 32'(OVF), 32'd1);
      check("bp_valid", 32'(EVT_VALID), 32'd1);
      check("bp_head", 32'(EVT_COUNT), 32'd1);
      check("bp_sync", 32'(COUNT_SYNC), 32'd5);
      pops = 0;
      EVT_READY = 1'b1;
      drain("bp");
      check("bp_pops", 32'(pops), 32'(DEPTH));
      check("bp_sb_empty", 32'(sb.size()), 32'd0);
      check("bp_ovf_sticky", 32'(OVF), 32'd1);

      // Reset mid-operation discards queued events and clears OVF
      EVT_READY = 1'b0;
      drive(4'd6, 1'b1, 4'd15);
      repeat (4) @(posedge CLK);
      #1;
      check("mid_valid_before", 32'(EVT_VALID), 32'd1);
      COUNT_IN = 4'd0;
      RESET_N  = 1'b0;
      #1;
      check("mid_valid", 32'(EVT_VALID), 32'd0);
      check("mid_ovf", 32'(OVF), 32'd0);
      check("mid_sync", 32'(COUNT_SYNC), 32'd0);
      check("mid_evt_count", 32'(EVT_COUNT), 32'd0);
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (6) @(posedge CLK);
      #1;
      check("zero_no_event", 32'(EVT_VALID), 32'd0);
      check("zero_sync", 32'(COUNT_SYNC), 32'd0);

      // Full FIFO with push and pop on the same edge
      for (int v = 1; v <= 4; v++) begin
         drive(4'(v), 1'b1, 4'd15);
         sb.push_back(mk(4'(v), 3'b000));
         repeat (3) @(posedge CLK);
      end
      repeat (2) @(posedge CLK);
      #1;
      check("full_valid", 32'(EVT_VALID), 32'd1);
      check("full_ovf", 32'(OVF), 32'd0);
      drive(4'd5, 1'b1, 4'd15);
      sb.push_back(mk(4'd5, 3'b000));
      repeat (3) @(posedge CLK);
      #1;
      EVT_READY = 1'b1;
      @(posedge CLK);
      #1;
      EVT_READY = 1'b0;
      check("pp_ovf", 32'(OVF), 32'd0);
      check("pp_head", 32'(EVT_COUNT), 32'd2);
      check("pp_sync", 32'(COUNT_SYNC), 32'd5);
      check("pp_valid", 32'(EVT_VALID), 32'd1);
      pops = 0;
      EVT_READY = 1'b1;
      drain("pp");
      check("pp_pops", 32'(pops), 32'(DEPTH));
      check("pp_sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ripple_count_monitor.md
# ripple_count_monitor

Downstream consumer of the asynchronous 4-bit up/down ripple counter. It synchronises the counter's COUNT and UPDN lines into the system CLK domain and rejects ripple-transition glitches with a stability filter. Each accepted value is classified as wrap, compare match or step skip. Accepted values and their flags are queued in a small event FIFO with a valid/ready handshake toward the controller.

## Interface
Parameters:
- WIDTH, 4: width of counter value.
- STABLE_CYCLES, 2: consecutive identical synchronised samples needed for acceptance. Legal range 1..7.
- DEPTH, 4: event FIFO entries. Power of two, 2..16.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- COUNT_IN  in  WIDTH  ripple counter value; asynchronous to CLK.
- UPDN_IN  in  1  counter direction, 1 = up; asynchronous to CLK.
- CMP_VAL  in  WIDTH  compare value; quasi-static, sampled directly.
- COUNT_SYNC  out  WIDTH  last accepted count.
- CHANGE  out  1  one-cycle pulse on each acceptance.
- EVT_VALID  out  1  FIFO non-empty.
- EVT_READY  in  1  consumer accepts head entry.
- EVT_COUNT  out  WIDTH  head entry count.
- EVT_FLAGS  out  3  head entry flags: {SKIP, MATCH, WRAP}.
- OVF  out  1  sticky; an event was dropped.

## Operation
- Synchroniser:
  - Two-flop chain per bit for COUNT_IN and UPDN_IN, giving s1 then s2.
  - No Gray assumption; the filter below handles multi-bit skew.
- Stability filter:
  - Run counter r, saturating at 7. r resets to 1 when s2 differs from its previous-cycle value, otherwise increments.
  - Acceptance when r ≥ STABLE_CYCLES and s2 ≠ COUNT_SYNC.
  - A value equal to COUNT_SYNC is never re-accepted.
- On acceptance (new = s2, old = COUNT_SYNC, dir = synchronised UPDN):
  - COUNT_SYNC ← new; CHANGE = 1 for one cycle.
  - WRAP: dir=1 with old = 2^WIDTH−1 and new = 0, or dir=0 with old = 0 and new = 2^WIDTH−1.
  - MATCH: new == CMP_VAL.
  - SKIP: new ≠ old+1 mod 2^WIDTH (dir=1), or new ≠ old−1 mod 2^WIDTH (dir=0).
  - Push {new, flags} into the FIFO.
- FIFO:
  - EVT_VALID = not empty. EVT_COUNT/EVT_FLAGS show the head entry and are held stable while VALID=1 and READY=0.
  - Pop on VALID & READY.
  - Push while full with no pop in the same cycle: entry dropped, OVF ← 1. OVF clears only on reset.
  - Push and pop in the same cycle while full: both succeed; occupancy unchanged.
  - Push and pop in the same cycle while empty is not possible, because VALID = 0.
- Reset (RESET_N low, any time): synchronisers, r, COUNT_SYNC = 0, CHANGE = 0, FIFO emptied (EVT_VALID = 0, EVT_COUNT = 0, EVT_FLAGS = 0), OVF = 0.
  - Reset mid-operation discards all queued events.
  - After release, a counter also at 0 produces no event.

## Timing
- Latency: the new value is first captured by s1 at edge E0 and by s2 at edge E1.
  - Acceptance registers at edge E1+STABLE_CYCLES: COUNT_SYNC, CHANGE and the FIFO write all happen at this edge.
  - Default case: 3 edges after E0.
- EVT_VALID rises at the same edge as the push when the FIFO was empty. No FIFO bypass.
- Glitch rejection: any s2 value held for fewer than STABLE_CYCLES edges produces no acceptance.
- Sustained throughput: one acceptance per STABLE_CYCLES+1 cycles minimum. The counter must change no faster than this for lossless monitoring.

## Configuration
- RCM_SKIP_DETECT_EN:
  - Defined: SKIP computed as above.
  - Undefined: the SKIP flag bit is tied to 0 and the comparison logic is removed. WRAP and MATCH are unaffected.

## Test plan
- Reset: hold RESET_N low with COUNT_IN = 5, then release. Required: COUNT_SYNC = 0, EVT_VALID = 0, OVF = 0 during reset. With STABLE_CYCLES = 2, COUNT_SYNC = 5 at the 3rd edge after the first capture, and the entry has flags SKIP=1 (with the macro defined).
- Up wrap: UPDN_IN=1, step COUNT_IN 14→15→0, each value held 8 cycles, EVT_READY=1. Required: events 15 with flags 000, then 0 with flags 001 (WRAP).
- Glitch: COUNT_IN 7→6 for 1 cycle, then →8, held, with STABLE_CYCLES=2. Required: a single event, count 8, no event for 6.
- Compare and down step: CMP_VAL=3, UPDN_IN=0, COUNT_IN 4→3. Required: event count 3 with flags 010.
- Backpressure: EVT_READY=0 with DEPTH+1 accepted values. Required: the first DEPTH values are retained in order, OVF=1, and EVT_VALID stays high; draining returns exactly DEPTH entries.
- Full with simultaneous push and pop: the FIFO is full, EVT_READY=1 in the same cycle as an acceptance. Required: occupancy stays at DEPTH, the head advances, OVF stays 0.
